// File: rtl/regfile_dbg_arbiter.sv
// Arbitrates the 65C02 register file op/DI port between the microcode core and a debug monitor.
// Optional forced-grant timeout in WAIT is enabled by defining REGFILE_ARB_TIMEOUT_EN.
module regfile_dbg_arbiter #(
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       rdy,
    input  logic [6:0] core_op,
    input  logic [7:0] core_di,
    input  logic       core_sync,
    output logic       core_rdy,
    input  logic       dbg_req,
    input  logic       dbg_we,
    input  logic [3:0] dbg_addr,
    input  logic [7:0] dbg_wdata,
    output logic       dbg_ack,
    output logic       dbg_err,
    output logic [7:0] dbg_rdata,
    output logic [6:0] rf_op,
    output logic [7:0] rf_di,
    input  logic [7:0] rf_do,
    output logic       rf_rdy,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_err;
    logic       w_err_next;
    logic [7:0] r_rdata;
    logic       w_force;

`ifdef REGFILE_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_cnt;

    assign w_force = (r_cnt == TIMEOUT_W'(TIMEOUT)) && rdy;

    // Zero outside WAIT, so every entry into WAIT starts counting from 0.
    always_ff @(posedge clk) begin
        if (RST || r_state != S_WAIT || w_next != S_WAIT) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    logic [TIMEOUT_W-1:0] w_unused_timeout;

    assign w_force          = 1'b0;
    assign w_unused_timeout = TIMEOUT_W'(TIMEOUT);
`endif

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
            r_rdata <= 8'h00;
        end else begin
            r_state <= w_next;
            r_err   <= w_err_next;
            if (r_state == S_ACCESS && !dbg_we) begin
                r_rdata <= rf_do;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_err_next = r_err;
        case (r_state)
            S_IDLE: begin
                if (dbg_req) begin
                    // Only A/X/Y/S (0-3) are writable; reject without touching the regfile.
                    if (dbg_we && dbg_addr[3:2] != 2'b00) begin
                        w_next     = S_RESP;
                        w_err_next = 1'b1;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!dbg_req) begin
                    w_next = S_IDLE;
                end else if ((core_sync && rdy) || w_force) begin
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_next     = S_RESP;
                w_err_next = 1'b0;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        rf_op    = core_op;
        rf_di    = core_di;
        rf_rdy   = rdy;
        core_rdy = rdy;
        case (r_state)
            S_ACCESS: begin
                core_rdy = 1'b0;
                rf_rdy   = 1'b1;
                rf_op    = {dbg_we, dbg_addr[1:0], dbg_addr};
                rf_di    = dbg_wdata;
            end
            S_RESP: begin
                // A rejected access never stalled the core, so its response stays pass-through.
                if (!r_err) begin
                    core_rdy = 1'b0;
                    rf_op[6] = 1'b0;
                end
            end
            default: ;
        endcase
        if (RST) begin
            rf_op[6] = 1'b0;
        end
    end

    assign dbg_ack   = (r_state == S_RESP);
    assign dbg_err   = (r_state == S_RESP) && r_err;
    assign dbg_rdata = r_rdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_regfile_dbg_arbiter.sv
// Bench for regfile_dbg_arbiter: behavioural regfile, vector table, scoreboard of debug responses.
module tb_regfile_dbg_arbiter;

    logic       clk;
    logic       RST;
    logic       rdy;
    logic [6:0] core_op;
    logic [7:0] core_di;
    logic       core_sync;
    logic       core_rdy;
    logic       dbg_req;
    logic       dbg_we;
    logic [3:0] dbg_addr;
    logic [7:0] dbg_wdata;
    logic       dbg_ack;
    logic       dbg_err;
    logic [7:0] dbg_rdata;
    logic [6:0] rf_op;
    logic [7:0] rf_di;
    logic [7:0] rf_do;
    logic       rf_rdy;
    logic [1:0] dbg_state;

    regfile_dbg_arbiter #(.TIMEOUT(4), .TIMEOUT_W(8)) dut (
        .clk(clk), .RST(RST), .rdy(rdy),
        .core_op(core_op), .core_di(core_di), .core_sync(core_sync), .core_rdy(core_rdy),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
        .rf_op(rf_op), .rf_di(rf_di), .rf_do(rf_do), .rf_rdy(rf_rdy),
        .dbg_state(dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural register file: write regs[wr_sel] when rdy & we, combinational read of rd_sel
    logic [7:0] regs [16];
    logic       rf_init;

    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= (i == 2) ? 8'h41 : (i == 5) ? 8'h01 : 8'(8'h10 + i);
            end
        end else if (rf_rdy && rf_op[6]) begin
            regs[{2'b00, rf_op[5:4]}] <= rf_di;
        end
    end
    assign rf_do = regs[rf_op[3:0]];

    // scoreboard: {dbg_err, dbg_rdata} expected at each dbg_ack
    logic [8:0] exp_q[$];
    int n_checks;
    int n_fail;

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        int         sync_dly;
        logic       exp_err;
        logic [7:0] exp_rdata;
        int         exp_lat;
        int         exp_stall;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one debug request starting just after a posedge; returns ack cycle and stall count.
    task automatic do_req(input logic we, input logic [3:0] addr, input logic [7:0] wd,
                          input int sync_dly, input logic [6:0] cop, input logic [7:0] cdi,
                          output int lat, output int stalls);
        logic [8:0] e;
        dbg_req   = 1'b1;
        dbg_we    = we;
        dbg_addr  = addr;
        dbg_wdata = wd;
        core_op   = cop;
        core_di   = cdi;
        core_sync = (sync_dly == 0);
        lat       = -1;
        stalls    = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!core_rdy) stalls++;
            if (dbg_ack) begin
                lat = c;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_ack_resp", {23'd0, dbg_err, dbg_rdata}, {23'd0, e});
                end
                break;
            end
            @(posedge clk);
            #1;
            if (c + 1 >= sync_dly) core_sync = 1'b1;
        end
        if (lat < 0) check("ack_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        dbg_req   = 1'b0;
        core_op   = 7'h00;
        core_sync = 1'b0;
    endtask

    task automatic core_write(input logic [1:0] sel, input logic [7:0] val);
        core_op = {1'b1, sel, 4'h0};
        core_di = val;
        @(posedge clk);
        #1;
        core_op = 7'h00;
    endtask

    int lat;
    int stalls;
    int acks;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{1'b0, 4'd2,  8'h00, 0, 1'b0, 8'h41, 3, 2};
        vecs[1] = '{1'b1, 4'd0,  8'h5A, 0, 1'b0, 8'h41, 3, 2};
        vecs[2] = '{1'b0, 4'd0,  8'h00, 1, 1'b0, 8'h5A, 3, 2};
        vecs[3] = '{1'b1, 4'd5,  8'hEE, 0, 1'b1, 8'h5A, 1, 0};
        vecs[4] = '{1'b0, 4'd5,  8'h00, 0, 1'b0, 8'h01, 3, 2};
        vecs[5] = '{1'b0, 4'd15, 8'h00, 3, 1'b0, 8'h1F, 5, 2};
        vecs[6] = '{1'b1, 4'd3,  8'hC3, 2, 1'b0, 8'h1F, 4, 2};
        vecs[7] = '{1'b0, 4'd3,  8'h00, 0, 1'b0, 8'hC3, 3, 2};

        // reset, with a core write op presented to prove it is blocked
        RST = 1'b1; rdy = 1'b1; core_op = 7'h7F; core_di = 8'h99; core_sync = 1'b0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 4'd0; dbg_wdata = 8'h00; rf_init = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_ack", {31'd0, dbg_ack}, 32'd0);
        check("rst_err", {31'd0, dbg_err}, 32'd0);
        check("rst_rdata", {24'd0, dbg_rdata}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        check("rst_rf_op_we_gated", {25'd0, rf_op}, 32'h3F);
        @(posedge clk);
        #1;
        RST = 1'b0;
        rdy = 1'b0;
        @(negedge clk);
        check("idle_rf_op", {25'd0, rf_op}, 32'h7F);
        check("idle_rf_di", {24'd0, rf_di}, 32'h99);
        check("idle_rf_rdy", {31'd0, rf_rdy}, 32'd0);
        check("idle_core_rdy", {31'd0, core_rdy}, 32'd0);
        @(posedge clk);
        #1;
        rdy = 1'b1; core_op = 7'h00; rf_init = 1'b1;
        @(posedge clk);
        #1;
        rf_init = 1'b0;
        @(negedge clk);
        check("idle_core_rdy_hi", {31'd0, core_rdy}, 32'd1);
        @(posedge clk);
        #1;

        // table-driven debug accesses
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({vecs[i].exp_err, vecs[i].exp_rdata});
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sync_dly, 7'h00, 8'h00, lat, stalls);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_stalls", i), stalls, vecs[i].exp_stall);
        end
        @(negedge clk);
        check("reg0_after_write", {24'd0, regs[0]}, 32'h5A);
        check("reg3_after_write", {24'd0, regs[3]}, 32'hC3);
        check("reg5_untouched", {24'd0, regs[5]}, 32'h01);
        @(posedge clk);
        #1;

        // core writes before, during and after a stalled read
        core_write(2'd1, 8'h11);
        @(negedge clk);
        check("core_write_before", {24'd0, regs[1]}, 32'h11);
        @(posedge clk);
        #1;
        exp_q.push_back({1'b0, 8'h22});
        do_req(1'b0, 4'd1, 8'h00, 0, 7'b1_01_0000, 8'h22, lat, stalls);
        check("core_during_latency", lat, 3);
        check("core_during_stalls", stalls, 2);
        core_write(2'd1, 8'h66);
        @(negedge clk);
        check("core_write_after", {24'd0, regs[1]}, 32'h66);
        @(posedge clk);
        #1;

        // collision: core writes A in the grant cycle, debug write to A lands one edge later
        exp_q.push_back({1'b0, 8'h22});
        do_req(1'b1, 4'd2, 8'h77, 0, 7'b1_10_0000, 8'h33, lat, stalls);
        check("collision_latency", lat, 3);
        @(negedge clk);
        check("collision_final_A", {24'd0, regs[2]}, 32'h77);
        @(posedge clk);
        #1;

        // abandon in WAIT: no ack, no write
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 4'd1; dbg_wdata = 8'hEE; core_sync = 1'b0;
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (dbg_ack) acks++;
            @(posedge clk);
            #1;
        end
        dbg_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (dbg_ack) acks++;
            @(posedge clk);
            #1;
        end
        check("abandon_no_ack", acks, 0);
        check("abandon_state_idle", {30'd0, dbg_state}, 32'd0);
        check("abandon_no_write", {24'd0, regs[1]}, 32'h66);

        // reset asserted during the ACCESS cycle of a write
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 4'd3; dbg_wdata = 8'hAA; core_sync = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_mid_in_access", {30'd0, dbg_state}, 32'd2);
        RST = 1'b1;
        @(posedge clk);
        #1;
        RST = 1'b0; dbg_req = 1'b0; core_sync = 1'b0;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (dbg_ack) acks++;
        end
        check("rst_mid_no_ack", acks, 0);
        check("rst_mid_reg_kept", {24'd0, regs[3]}, 32'hC3);
        check("rst_mid_rdata_clr", {24'd0, dbg_rdata}, 32'h00);
        @(posedge clk);
        #1;

        // recovery read after reset
        exp_q.push_back({1'b0, 8'hC3});
        do_req(1'b0, 4'd3, 8'h00, 0, 7'h00, 8'h00, lat, stalls);
        check("recover_latency", lat, 3);

        // WAIT with core_sync held low
`ifdef REGFILE_ARB_TIMEOUT_EN
        exp_q.push_back({1'b0, 8'h77});
        do_req(1'b0, 4'd2, 8'h00, 100000, 7'h00, 8'h00, lat, stalls);
        check("timeout_latency", lat, 7);
        check("timeout_stalls", stalls, 2);
`else
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 4'd2; core_sync = 1'b0;
        acks = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (dbg_ack || !core_rdy) acks++;
        end
        check("no_timeout_no_ack", acks, 0);
        @(posedge clk);
        #1;
        dbg_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
